// File: rtl/barrel_rot_ctrl.sv
// Command sequencer for an N-entry rotating register b and an N-entry register file r.
// Optional sticky alignment-invariant checker enabled by defining BARREL_INV_CHECK_EN.
module barrel_rot_ctrl #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [N*W-1:0] cmd_data,
    input  logic [W-1:0]   cmd_amt,
    output logic           rsp_valid,
    output logic           rsp_match,
    output logic [W:0]     rsp_count,
    output logic           busy,
    output logic [N*W-1:0] b_out,
    output logic [N*W-1:0] r_out,
    output logic           inv_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_SRCH = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] OP_LOAD_R = 2'd0;
    localparam logic [1:0] OP_LOAD_B = 2'd1;
    localparam logic [1:0] OP_ROTATE = 2'd2;
    localparam logic [1:0] OP_SEARCH = 2'd3;

    localparam logic [W:0] N_CNT = (W+1)'(N);

    // One parallel step: entry i takes old entry i+1, the top entry takes old entry 0.
    function automatic logic [N*W-1:0] rot_step(input logic [N*W-1:0] v);
        return {v[W-1:0], v[N*W-1:W]};
    endfunction

    logic [1:0]     state_r, state_s;
    logic [N*W-1:0] b_r, b_s, r_r, r_s, b_step_s;
    logic [W:0]     cnt_r, cnt_s, amt_r, amt_s, cnt_inc_s;
    logic           match_r, match_s;
    logic [W:0]     count_r, count_s;
    logic           rsp_valid_r, cmd_ready_r, busy_r;

    // Next-state and datapath decode; loads and immediate completions resolve on the accept edge.
    always_comb begin
        state_s   = state_r;
        b_s       = b_r;
        r_s       = r_r;
        cnt_s     = cnt_r;
        amt_s     = amt_r;
        match_s   = match_r;
        count_s   = count_r;
        b_step_s  = rot_step(b_r);
        cnt_inc_s = cnt_r + {{W{1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_s = {(W+1){1'b0}};
                    case (cmd_op)
                        OP_LOAD_R: begin
                            r_s     = cmd_data;
                            match_s = 1'b0;
                            count_s = {(W+1){1'b0}};
                            state_s = ST_RESP;
                        end
                        OP_LOAD_B: begin
                            b_s     = cmd_data;
                            match_s = 1'b0;
                            count_s = {(W+1){1'b0}};
                            state_s = ST_RESP;
                        end
                        OP_ROTATE: begin
                            amt_s = {1'b0, cmd_amt};
                            if (cmd_amt == {W{1'b0}}) begin
                                match_s = 1'b0;
                                count_s = {(W+1){1'b0}};
                                state_s = ST_RESP;
                            end else begin
                                state_s = ST_ROT;
                            end
                        end
                        OP_SEARCH: begin
                            // Already aligned: report zero rotations without entering SRCH.
                            if (b_r == r_r) begin
                                match_s = 1'b1;
                                count_s = {(W+1){1'b0}};
                                state_s = ST_RESP;
                            end else begin
                                state_s = ST_SRCH;
                            end
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ROT: begin
                b_s   = b_step_s;
                cnt_s = cnt_inc_s;
                if (cnt_inc_s == amt_r) begin
                    match_s = 1'b0;
                    count_s = cnt_inc_s;
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_ROT;
                end
            end
            ST_SRCH: begin
                // Step and compare the stepped value, so a hit after s steps costs s cycles.
                b_s   = b_step_s;
                cnt_s = cnt_inc_s;
                if (b_step_s == r_r) begin
                    match_s = 1'b1;
                    count_s = cnt_inc_s;
                    state_s = ST_RESP;
                end else if (cnt_inc_s == N_CNT) begin
                    match_s = 1'b0;
                    count_s = N_CNT;
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_SRCH;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            b_r         <= {(N*W){1'b0}};
            r_r         <= {(N*W){1'b0}};
            cnt_r       <= {(W+1){1'b0}};
            amt_r       <= {(W+1){1'b0}};
            match_r     <= 1'b0;
            count_r     <= {(W+1){1'b0}};
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            b_r         <= b_s;
            r_r         <= r_s;
            cnt_r       <= cnt_s;
            amt_r       <= amt_s;
            match_r     <= match_s;
            count_r     <= count_s;
            rsp_valid_r <= (state_s == ST_RESP);
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_match = match_r;
    assign rsp_count = count_r;
    assign b_out     = b_r;
    assign r_out     = r_r;

`ifdef BARREL_INV_CHECK_EN
    // Any entry pair of b matching r must also match at the following (cyclic) position.
    function automatic logic inv_ok(input logic [N*W-1:0] b, input logic [N*W-1:0] r);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if ((b[W*j +: W] == r[W*i +: W]) &&
                    (b[W*((j+1)%N) +: W] != r[W*((i+1)%N) +: W])) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
        end
        return ok;
    endfunction

    logic inv_err_r;

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            inv_err_r <= 1'b0;
        end else if (!inv_ok(b_r, r_r)) begin
            inv_err_r <= 1'b1;
        end else begin
            inv_err_r <= inv_err_r;
        end
    end

    assign inv_err = inv_err_r;
`else
    assign inv_err = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_rot_ctrl.sv
// Self-checking bench for barrel_rot_ctrl: directed cases plus random commands
// against an array-based reference model.
module tb_barrel_rot_ctrl;

    localparam int N = 4;
    localparam int W = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [N*W-1:0] cmd_data;
    logic [W-1:0]   cmd_amt;
    logic           rsp_valid;
    logic           rsp_match;
    logic [W:0]     rsp_count;
    logic           busy;
    logic [N*W-1:0] b_out;
    logic [N*W-1:0] r_out;
    logic           inv_err;

    int n_cmp = 0;
    int n_err = 0;

    int b_m [N];
    int r_m [N];
    int last_cnt;
    int last_match;
    int inv_exp;

    barrel_rot_ctrl #(.N(N), .W(W)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt), .rsp_valid(rsp_valid),
        .rsp_match(rsp_match), .rsp_count(rsp_count), .busy(busy), .b_out(b_out),
        .r_out(r_out), .inv_err(inv_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pack(input int a [N]);
        int v = 0;
        for (int i = 0; i < N; i++) v = v + (a[i] << (W * i));
        return v;
    endfunction

    function automatic int entry(input int data, input int i);
        return (data >> (W * i)) % N;
    endfunction

    function automatic int inv_violated();
        int bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (b_m[j] == r_m[i] && b_m[(j+1)%N] != r_m[(i+1)%N]) bad = 1;
        return bad;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            b_m[i] = 0;
            r_m[i] = 0;
        end
        last_cnt = 0;
        last_match = 0;
        inv_exp = 0;
    endfunction

    // Issue one command, wait (bounded) for its response and compare against the model.
    task automatic do_cmd(input int op, input int data, input int amt);
        int exp_lat, exp_cnt, exp_match, lat, s_hit;
        int tmp [N];
        @(negedge clock);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_data  = data[N*W-1:0];
        cmd_amt   = amt[W-1:0];
        @(posedge clock);
        exp_match = 0;
        case (op)
            0: begin for (int i = 0; i < N; i++) r_m[i] = entry(data, i); exp_cnt = 0; end
            1: begin for (int i = 0; i < N; i++) b_m[i] = entry(data, i); exp_cnt = 0; end
            2: begin
                for (int i = 0; i < N; i++) tmp[i] = b_m[(i + amt) % N];
                b_m = tmp;
                exp_cnt = amt;
            end
            default: begin
                s_hit = -1;
                for (int s = N - 1; s >= 0; s--) begin
                    int eq = 1;
                    for (int i = 0; i < N; i++) if (b_m[(i + s) % N] != r_m[i]) eq = 0;
                    if (eq == 1) s_hit = s;
                end
                if (s_hit >= 0) begin
                    for (int i = 0; i < N; i++) tmp[i] = b_m[(i + s_hit) % N];
                    b_m = tmp;
                    exp_cnt = s_hit;
                    exp_match = 1;
                end else begin
                    exp_cnt = N;
                end
            end
        endcase
        exp_lat = exp_cnt + 1;
`ifdef BARREL_INV_CHECK_EN
        if (inv_violated() != 0) inv_exp = 1;
`endif
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_data  = N*W'($urandom);
        cmd_amt   = W'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_match", rsp_match, exp_match);
        check("rsp_count", rsp_count, exp_cnt);
        check("b_out", b_out, pack(b_m));
        check("r_out", r_out, pack(r_m));
        check("busy_in_resp", busy, 1);
        last_cnt = exp_cnt;
        last_match = exp_match;
        @(negedge clock);
        check("rsp_pulse_end", rsp_valid, 0);
        check("ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
        check("count_held", rsp_count, last_cnt);
        check("match_held", rsp_match, last_match);
        check("inv_err", inv_err, inv_exp);
    endtask

    initial begin
        // Reset with a command presented: it must be dropped.
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        cmd_data = 8'hFF;
        cmd_amt = 2'd0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clock);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_match", rsp_match, 0);
        check("reset_rsp_count", rsp_count, 0);
        check("reset_b", b_out, 0);
        check("reset_r_dropped", r_out, 0);
        check("reset_inv", inv_err, 0);

        do_cmd(0, 8'hE4, 0);
        do_cmd(1, 8'hE4, 0);
        do_cmd(2, 0, 1);
        check("rot1_b", b_out, 8'h39);
        do_cmd(1, 8'h93, 0);
        do_cmd(3, 0, 0);
        check("search_hit_b", b_out, 8'hE4);
        do_cmd(3, 0, 0);
        check("search_zero_count", rsp_count, 0);
        do_cmd(1, 8'hB4, 0);
        do_cmd(3, 0, 0);
        check("search_miss_count", rsp_count, 4);
        do_cmd(2, 0, 0);
        do_cmd(2, 0, 3);

        // Reset in the middle of a 3-step rotation.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_amt = 2'd3;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        check("abort_no_rsp1", rsp_valid, 0);
        @(negedge clock);
        check("abort_no_rsp2", rsp_valid, 0);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check("abort_no_rsp3", rsp_valid, 0);
        check("abort_b", b_out, 0);
        check("abort_r", r_out, 0);
        check("abort_count", rsp_count, 0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready", cmd_ready, 1);
        check("abort_inv", inv_err, 0);

        // Random commands; half the LOAD_B loads are a rotation of r so SEARCH often hits.
        for (int t = 0; t < 60; t++) begin
            int op, data, sh;
            op = $urandom_range(0, 3);
            data = $urandom_range(0, 255);
            if (op == 1 && $urandom_range(0, 1) == 1) begin
                sh = $urandom_range(0, N - 1);
                data = 0;
                for (int i = 0; i < N; i++) data = data + (r_m[(i + N - sh) % N] << (W * i));
            end
            do_cmd(op, data, $urandom_range(0, N - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
